mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
// - Memory-side responder for the core's load/store path: accepts one request at a time
//   from the control FSM (instruction fetch, LOAD, STORE).
// - Serves each request byte-serially from an internal little-endian byte array.
// - Returns sign/zero-extended read data with a valid strobe; suits the multi-cycle,
//   nibble-serial core, which stalls until the response arrives.
// PARAMETERS
// - DEPTH_BYTES   default 'h10000  number of byte locations; valid addresses 0..DEPTH_BYTES-1
// - ADDR_W        default 32       request address width
// PORTS
// - clk           in   1      clock; all state changes on posedge
// - reset         in   1      synchronous, active-high reset
// - req_valid     in   1      request present
// - req_ready     out  1      responder can accept a request
// - req_write     in   1      1 = store, 0 = load/fetch
// - req_width     in   2      0 = byte, 1 = half, 2 = word; 3 = illegal
// - req_unsigned  in   1      loads only: 1 = zero-extend, 0 = sign-extend
// - req_addr      in   ADDR_W byte address of lowest byte
// - req_wdata     in   32     store data; low 1/2/4 bytes used
// - resp_valid    out  1      one-cycle pulse: access finished
// - resp_rdata    out  32     extended load data; 0 for stores and errors
// - resp_error    out  1      qualifies resp_valid: request rejected, no memory change
// BEHAVIOUR
// - Synchronous, active-high reset:
//   - state <= IDLE; req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0.
//   - Byte array contents are NOT reset.
// - Handshake: request accepted on a posedge with req_valid && req_ready.
//   - All req_* fields are latched at that edge; inputs are ignored afterwards.
//   - req_ready=1 only in IDLE.
// - FSM states:
//   - IDLE: on accept, if legal -> ACCESS with byte counter = 0 and n = 1/2/4;
//     if illegal -> RESPOND with error.
//   - ACCESS: one byte per cycle at addr+k, k = 0..n-1.
//     - Write: mem[addr+k] <= wdata[8k+:8].
//     - Read: rbuf[8k+:8] <= mem[addr+k].
//     - After byte n-1 -> RESPOND.
//   - RESPOND: resp_valid=1 for exactly this cycle; resp_rdata/resp_error valid this cycle
//     only, then 0 again. -> IDLE.
// - Latency: accept edge to resp_valid high is n+1 cycles (byte 2, half 3, word 5).
//   - Error response: 1 cycle.
//   - Back-to-back: a new request can be accepted in the cycle after resp_valid.
// - Read extension:
//   - Byte: bit 7 extended to 32 bits. Half: bit 15 extended. Word: passed unchanged.
//   - Sign extension only when req_unsigned=0; otherwise zero-fill.
// - Illegal request:
//   - req_width=3, or addr+n-1 > DEPTH_BYTES-1 (computed at ADDR_W+1 bits, so no
//     wrap-around).
//   - Sets resp_error=1, resp_rdata=0; memory untouched.
// - Misaligned but in-range accesses are legal unless the option below is compiled in.
// - Reset mid-ACCESS: aborts with no response.
//   - Bytes already written stay written; remaining bytes are not written.
// - req_valid while busy: ignored (req_ready=0); the requester holds it.
// - Reads and writes never overlap: the single port is owned by the FSM.
// CONFIGURATION
// - MEM_RESPONDER_ALIGN_CHECK_EN defined:
//   - half requiring addr[0]=0 and word requiring addr[1:0]=0 is checked;
//   - a violation is an illegal request (1-cycle error response, no memory change).
// - Undefined: no alignment check; misaligned accesses proceed byte-serially.
// TESTING
// - Word store 'hDEADBEEF @ 'h100, then word load @ 'h100 -> resp_rdata='hDEADBEEF;
//   resp_valid 5 cycles after each accept.
// - Byte load @ 'h100 (byte='hEF), signed -> 'hFFFFFFEF; unsigned -> 'h000000EF.
// - Half store 'h8001 @ 'h0FF (misaligned, macro off), signed half load @ 'h0FF
//   -> 'hFFFF8001; bytes 'h0FF='h01, 'h100='h80.
// - Word load @ DEPTH_BYTES-2 -> resp_error=1, rdata=0 one cycle after accept;
//   req_width=3 -> same.
// - Reset asserted in cycle 2 of a word store of 'h11223344 @ 'h40 -> no resp_valid;
//   'h40='h44 and 'h41='h33 written; 'h42 and 'h43 unchanged; req_ready=1 the next cycle.
// - MEM_RESPONDER_ALIGN_CHECK_EN: word load @ 'h102 -> error; word load @ 'h104 -> normal.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: byte-serial little-endian byte array serving one load/store at a time.
// Latency: resp_valid is high n+1 cycles after accept (n = 1/2/4 bytes); illegal requests respond after 1 cycle.
// Backpressure: req_ready is high only in IDLE; a request is held by the requester until accepted.
// Optional: define MEM_RESPONDER_ALIGN_CHECK_EN to reject misaligned half/word requests.
module mem_responder #(
  parameter int unsigned DEPTH_BYTES = 'h10000,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_width,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_error
);

  localparam int unsigned   IDX_W    = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam logic [ADDR_W:0] MAX_ADDR = (ADDR_W+1)'(DEPTH_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t state;

  logic [7:0] mem [DEPTH_BYTES];

  // Request fields captured at the accept edge
  logic              write_q;
  logic              unsigned_q;
  logic [1:0]        width_q;
  logic [1:0]        last_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [1:0]        cnt;
  logic [31:0]       rbuf;

  // Request decode
  logic [1:0]        req_last;
  logic [ADDR_W:0]   req_end;
  logic              req_illegal;

  // Datapath for the byte currently being transferred
  logic [ADDR_W-1:0] cur_addr;
  logic [IDX_W-1:0]  mem_idx;
  logic [7:0]        rd_byte;
  logic [7:0]        wr_byte;
  logic [31:0]       rbuf_next;
  logic              unused_hi_addr;

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [1:0] w, input logic uns);
    logic [31:0] r;
    case (w)
      2'd0:    r = {{24{~uns & v[7]}},  v[7:0]};
      2'd1:    r = {{16{~uns & v[15]}}, v[15:0]};
      default: r = v;
    endcase
    return r;
  endfunction

  // Legality of the presented request; end address computed one bit wider so it cannot wrap
  always_comb begin
    req_last    = 2'd0;
    req_illegal = 1'b0;
    case (req_width)
      2'd1:    req_last = 2'd1;
      2'd2:    req_last = 2'd3;
      default: req_last = 2'd0;
    endcase
    req_end = {1'b0, req_addr} + {{(ADDR_W-1){1'b0}}, req_last};
    if (req_width == 2'd3)    req_illegal = 1'b1;
    if (req_end > MAX_ADDR)   req_illegal = 1'b1;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if (req_width == 2'd1 && req_addr[0])          req_illegal = 1'b1;
    if (req_width == 2'd2 && req_addr[1:0] != 2'b00) req_illegal = 1'b1;
`endif
  end

  // Byte lane selection for the current step of the transfer
  always_comb begin
    cur_addr  = addr_q + ADDR_W'(cnt);
    mem_idx   = cur_addr[IDX_W-1:0];
    rd_byte   = mem[mem_idx];
    wr_byte   = wdata_q[{cnt, 3'b000} +: 8];
    rbuf_next = rbuf;
    rbuf_next[{cnt, 3'b000} +: 8] = rd_byte;
  end

  // Address bits above the array index are always zero for a legal in-range access
  assign unused_hi_addr = ^cur_addr[ADDR_W-1:IDX_W];

  // Store path: one byte per ACCESS cycle; a reset edge suppresses the pending byte
  always_ff @(posedge clk) begin
    if (!reset && state == ACCESS && write_q) begin
      mem[mem_idx] <= wr_byte;
    end
  end

  // Control FSM with registered handshake and response outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
      cnt        <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            write_q    <= req_write;
            unsigned_q <= req_unsigned;
            width_q    <= req_width;
            last_q     <= req_last;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            cnt        <= 2'd0;
            rbuf       <= 32'd0;
            req_ready  <= 1'b0;
            if (req_illegal) begin
              state      <= RESPOND;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'd0;
            end else begin
              state <= ACCESS;
            end
          end
        end
        ACCESS: begin
          rbuf <= rbuf_next;
          if (cnt == last_q) begin
            state      <= RESPOND;
            resp_valid <= 1'b1;
            resp_error <= 1'b0;
            resp_rdata <= write_q ? 32'd0 : extend(rbuf_next, width_q, unsigned_q);
          end else begin
            cnt <= cnt + 2'd1;
          end
        end
        RESPOND: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= 32'd0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          resp_valid <= 1'b0;
          resp_error <= 1'b0;
          resp_rdata <= 32'd0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed scenarios plus random loads/stores checked against a byte-array model.
// Latency is counted in negedges after the accept edge at which resp_valid is first seen (n+1, or 1 for errors).
// The requester holds req_valid until accepted; other request inputs are scrambled after acceptance.
module tb_mem_responder;

  localparam int unsigned DEPTH  = 'h10000;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic [1:0]        req_width = 2'd0;
  logic              req_unsigned = 1'b0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = '0;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] mdl [int];

  mem_responder #(.DEPTH_BYTES(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_width    (req_width),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference rules: size, legality, read extension
  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit model_illegal(input logic [1:0] w, input logic [31:0] a);
    longint unsigned last;
    if (w == 2'd3) return 1'b1;
    last = longint'(a) + longint'(nbytes(w)) - 1;
    if (last > longint'(DEPTH) - 1) return 1'b1;
`ifdef MEM_RESPONDER_ALIGN_CHECK_EN
    if ((a % nbytes(w)) != 0) return 1'b1;
`endif
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_read(input logic [1:0] w, input bit uns, input logic [31:0] a);
    longint v;
    int n;
    n = nbytes(w);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (longint'(mdl[int'(a) + i]) << (8 * i));
    if (!uns && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  // Issue one request, wait for its response, check the single-cycle pulse
  task automatic do_req(input string tag, input bit wr, input logic [1:0] w, input bit uns,
                        input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    int guard;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_width = w; req_unsigned = uns;
    req_addr = a; req_wdata = d;
    guard = 0;
    while (!req_ready && guard < 20) begin @(negedge clk); guard++; end
    check({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_write = 1'($urandom); req_width = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!resp_valid && lat < 20);
    check({tag, "_resp_seen"}, 32'(resp_valid), 32'd1);
    rd = resp_rdata;
    er = resp_error;
    @(negedge clk);
    check({tag, "_pulse_end"}, {resp_rdata[29:0], resp_error, resp_valid}, 32'd0);
    check({tag, "_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  // Full transaction checked against the model; model memory updated for successful stores
  task automatic txn(input string tag, input bit wr, input logic [1:0] w, input bit uns,
                     input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd, output logic er);
    bit ill;
    int lat;
    logic [31:0] exp_rd;
    ill = model_illegal(w, a);
    exp_rd = (ill || wr) ? 32'd0 : model_read(w, uns, a);
    do_req(tag, wr, w, uns, a, d, rd, er, lat);
    check({tag, "_err"}, 32'(er), 32'(ill));
    check({tag, "_rdata"}, rd, exp_rd);
    check({tag, "_lat"}, 32'(lat), ill ? 32'd1 : 32'(nbytes(w) + 1));
    if (!ill && wr) for (int i = 0; i < nbytes(w); i++) mdl[int'(a) + i] = d[8*i +: 8];
  endtask

  initial begin
    logic [31:0] rd;
    logic er;
    logic [1:0] w;
    logic [31:0] a;
    bit seen;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_outs", {resp_rdata[29:0], resp_error, resp_valid}, 32'd0);
    reset = 1'b0;

    // Word store / word load
    txn("st_w100", 1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, rd, er);
    txn("ld_w100", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er);
    check("ld_w100_const", rd, 32'hDEADBEEF);

    // Byte loads signed/unsigned
    txn("ld_b_s", 1'b0, 2'd0, 1'b0, 32'h100, 32'h0, rd, er);
    check("ld_b_s_const", rd, 32'hFFFFFFEF);
    txn("ld_b_u", 1'b0, 2'd0, 1'b1, 32'h100, 32'h0, rd, er);
    check("ld_b_u_const", rd, 32'h000000EF);

`ifndef MEM_RESPONDER_ALIGN_CHECK_EN
    // Misaligned half store straddling 0x0FF/0x100
    txn("st_h0ff", 1'b1, 2'd1, 1'b0, 32'h0FF, 32'h00008001, rd, er);
    txn("ld_h0ff", 1'b0, 2'd1, 1'b0, 32'h0FF, 32'h0, rd, er);
    check("ld_h0ff_const", rd, 32'hFFFF8001);
    txn("ld_b0ff", 1'b0, 2'd0, 1'b1, 32'h0FF, 32'h0, rd, er);
    check("ld_b0ff_const", rd, 32'h00000001);
    txn("ld_b100", 1'b0, 2'd0, 1'b1, 32'h100, 32'h0, rd, er);
    check("ld_b100_const", rd, 32'h00000080);
`else
    txn("al_w102", 1'b0, 2'd2, 1'b0, 32'h102, 32'h0, rd, er);
    check("al_w102_err", 32'(er), 32'd1);
    txn("al_w104", 1'b0, 2'd2, 1'b0, 32'h104, 32'h0, rd, er);
    check("al_w104_err", 32'(er), 32'd0);
`endif

    // Illegal requests: range end, width 3, address wrap
    txn("err_top", 1'b0, 2'd2, 1'b0, DEPTH - 2, 32'h0, rd, er);
    check("err_top_const", 32'(er), 32'd1);
    txn("err_w3", 1'b1, 2'd3, 1'b0, 32'h100, 32'h12345678, rd, er);
    check("err_w3_const", 32'(er), 32'd1);
    txn("err_wrap", 1'b0, 2'd2, 1'b0, 32'hFFFFFFFF, 32'h0, rd, er);
    txn("ok_last", 1'b1, 2'd0, 1'b0, DEPTH - 1, 32'h5A, rd, er);
    txn("st_h100", 1'b1, 2'd1, 1'b0, 32'h100, 32'h0000BEEF, rd, er);
    txn("ld_w100b", 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, rd, er);
    check("err_w3_nochange", rd, 32'hDEADBEEF);

    // Reset during a word store: first two bytes land, the rest do not
    txn("pre_w40", 1'b1, 2'd2, 1'b0, 32'h40, 32'hAABBCCDD, rd, er);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_width = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h40; req_wdata = 32'h11223344;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1 seen = seen | resp_valid; end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    seen = seen | resp_valid;
    @(negedge clk);
    check("rst_mid_no_resp", 32'(seen | resp_valid), 32'd0);
    check("rst_mid_ready", 32'(req_ready), 32'd1);
    mdl[32'h40] = 8'h44;
    mdl[32'h41] = 8'h33;
    txn("ld_w40", 1'b0, 2'd2, 1'b1, 32'h40, 32'h0, rd, er);
    check("ld_w40_const", rd, 32'hAABB3344);

    // Random traffic in an initialised window, plus occasional out-of-range words
    for (int i = 0; i < 16; i++) txn("init", 1'b1, 2'd2, 1'b0, 32'h300 + 32'(4 * i), $urandom, rd, er);
    for (int i = 0; i < 60; i++) begin
      w = 2'($urandom_range(0, 3));
      a = 32'h300 + 32'($urandom_range(0, 60));
      if ($urandom_range(0, 7) == 0) begin
        w = 2'd2;
        a = DEPTH - 32'($urandom_range(1, 3));
      end
      txn("rnd", 1'($urandom), w, 1'($urandom), a, $urandom, rd, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
